mx_opb_fwd_stage: RTL

//  Next-generation operand-B path at the decode->execute boundary. Selects the

---
 rtl/mx_opb_fwd_stage_pkg.sv | 22 ++
 rtl/mx_opb_fwd_stage_fwd_match.sv | 46 ++++
 rtl/mx_opb_fwd_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mx_opb_fwd_stage_pkg.sv
// Shared definitions for the operand-B forwarding stage: select encodings
// and default datapath/address widths.
package mx_opb_fwd_stage_pkg;

    // Which value the operand mux picks this cycle.
    typedef enum logic [1:0] {
        SEL_RB  = 2'd0,
        SEL_SE  = 2'd1,
        SEL_FWD = 2'd2
    } opb_sel_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_REGW  = 4;
    localparam int DEF_NSRC  = 2;
    localparam int DEF_CNTW  = 16;

    // Width of an index into NSRC sources; at least one bit.
    function automatic int idx_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/mx_opb_fwd_stage_fwd_match.sv
// NSRC-way priority comparator. Source 0 is the youngest and wins ties.
// Reports the winning index, whether the winner is a load (data not yet
// available) and a one-hot of the winner when it can be forwarded.
// Shared with the operand-A stage.
module mx_opb_fwd_stage_fwd_match
    import mx_opb_fwd_stage_pkg::*;
#(
    parameter int NSRC     = DEF_NSRC,
    parameter int REGW     = DEF_REGW,
    parameter bit ZERO_REG = 1'b1,
    parameter int IDXW     = idx_width(NSRC)
) (
    input  logic [REGW-1:0]      rb_addr_i,
    input  logic [NSRC-1:0]      src_valid_i,
    input  logic [NSRC*REGW-1:0] src_addr_i,
    input  logic [NSRC-1:0]      src_is_load_i,
    output logic                 any_hit_o,
    output logic                 load_hit_o,
    output logic [NSRC-1:0]      hit_oh_o,
    output logic [IDXW-1:0]      win_idx_o
);

    logic zero_addr;

    assign zero_addr = ZERO_REG && (rb_addr_i == '0);

    // Scan oldest to youngest so the youngest match is the last one written.
    // A younger load match therefore hides any older forwardable match.
    always_comb begin
        any_hit_o  = 1'b0;
        load_hit_o = 1'b0;
        hit_oh_o   = '0;
        win_idx_o  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_valid_i[i] && (src_addr_i[i*REGW +: REGW] == rb_addr_i) && !zero_addr) begin
                any_hit_o = 1'b1;
                win_idx_o = IDXW'(i);
            end
        end
        if (any_hit_o) begin
            load_hit_o          = src_is_load_i[win_idx_o];
            hit_oh_o[win_idx_o] = !load_hit_o;
        end
    end

endmodule

// File: rtl/mx_opb_fwd_stage.sv
// Operand-B path at the decode->execute boundary: picks register value,
// immediate or a forwarded value, raises stall on a load-use hazard,
// registers the operand into ID/EX and counts stall cycles (saturating).
//
// Handshake: a decode operand is transferred into ID/EX on a rising edge
// where ex_ready=1 and flush=0; out_valid then equals id_valid with a bubble
// inserted on a hazard. flush drops out_valid and wins over ex_ready. stall
// is purely combinational from the current inputs and ignores ex_ready/flush.
module mx_opb_fwd_stage
    import mx_opb_fwd_stage_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NSRC     = DEF_NSRC,
    parameter int REGW     = DEF_REGW,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNTW     = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_RB,
    input  logic [WIDTH-1:0]      in_SE,
    input  logic                  S_MXSE,
    input  logic [REGW-1:0]       rb_addr,
    input  logic                  id_valid,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*REGW-1:0]  src_addr,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_is_load,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic                  stall,
    output logic [NSRC-1:0]       fwd_hit,
    output logic [CNTW-1:0]       stall_cnt
);

    localparam int IDXW = idx_width(NSRC);

    logic            m_any_hit;
    logic            m_load_hit;
    logic [NSRC-1:0] m_hit_oh;
    logic [IDXW-1:0] m_win_idx;

    opb_sel_e        sel_kind;
    logic            hazard;
    logic [WIDTH-1:0] sel;

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

    mx_opb_fwd_stage_fwd_match #(
        .NSRC     (NSRC),
        .REGW     (REGW),
        .ZERO_REG (ZERO_REG),
        .IDXW     (IDXW)
    ) u_match (
        .rb_addr_i     (rb_addr),
        .src_valid_i   (src_valid),
        .src_addr_i    (src_addr),
        .src_is_load_i (src_is_load),
        .any_hit_o     (m_any_hit),
        .load_hit_o    (m_load_hit),
        .hit_oh_o      (m_hit_oh),
        .win_idx_o     (m_win_idx)
    );

    // Operand selection: the immediate bypasses matching entirely.
    always_comb begin
        sel_kind = SEL_RB;
        hazard   = 1'b0;
        fwd_hit  = '0;
        if (S_MXSE) begin
            sel_kind = SEL_SE;
        end else if (m_any_hit) begin
            if (m_load_hit) begin
                hazard = 1'b1;
            end else begin
                sel_kind = SEL_FWD;
                fwd_hit  = m_hit_oh;
            end
        end
        case (sel_kind)
            SEL_SE:  sel = in_SE;
            SEL_FWD: sel = src_data[int'(m_win_idx)*WIDTH +: WIDTH];
            default: sel = in_RB;
        endcase
    end

    assign stall = id_valid & hazard;

    // ID/EX next state: flush beats ex_ready; a hazard loads a bubble.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (ex_ready) begin
            out_d       = sel;
            out_valid_d = id_valid & ~hazard;
        end
        if (stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule
